// File: rtl/rca_pipe.sv
// Segment-pipelined ripple-carry adder/subtractor; RCA_PIPE_OVF_EN adds a signed-overflow output.
// Latency NSEG = WIDTH/SEG cycles, one result per cycle when not stalled.
// Backpressure: a global stall (out_valid && !out_ready) freezes every stage and drops in_ready.
module rca_pipe #(
    parameter int WIDTH = 16,
    parameter int SEG   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout
`ifdef RCA_PIPE_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int NSEG = WIDTH / SEG;

    generate
        if ((WIDTH % SEG) != 0) begin : g_bad_seg
            $error("rca_pipe: WIDTH must be a multiple of SEG");
        end
    endgenerate

    // Per-stage registers. Operands are shifted right by SEG each stage so the
    // segment to add is always in the low bits; sum bits enter at the top and
    // shift down, landing in order after the final stage.
    logic             v_q [NSEG];
    logic             c_q [NSEG];
    logic [WIDTH-1:0] s_q [NSEG];
    logic [WIDTH-1:0] a_q [NSEG];
    logic [WIDTH-1:0] b_q [NSEG];

    logic             stg_v [NSEG];
    logic             stg_c [NSEG];
    logic [WIDTH-1:0] stg_s [NSEG];
    logic [WIDTH-1:0] stg_a [NSEG];
    logic [WIDTH-1:0] stg_b [NSEG];
    logic [SEG:0]     seg_sum [NSEG];
    logic [WIDTH-1:0] nxt_s [NSEG];
    logic [WIDTH-1:0] nxt_a [NSEG];
    logic [WIDTH-1:0] nxt_b [NSEG];

    logic stall;

    assign stall     = v_q[NSEG-1] && !out_ready;
    assign in_ready  = !stall;
    assign out_valid = v_q[NSEG-1];
    assign s         = s_q[NSEG-1];
    assign cout      = c_q[NSEG-1];

    always_comb begin
        // Subtraction is a + ~b + 1, folded in before the first segment.
        stg_v[0] = in_valid;
        stg_c[0] = sub | cin;
        stg_s[0] = '0;
        stg_a[0] = a;
        stg_b[0] = sub ? ~b : b;
        for (int k = 1; k < NSEG; k++) begin
            stg_v[k] = v_q[k-1];
            stg_c[k] = c_q[k-1];
            stg_s[k] = s_q[k-1];
            stg_a[k] = a_q[k-1];
            stg_b[k] = b_q[k-1];
        end
        for (int k = 0; k < NSEG; k++) begin
            seg_sum[k] = {1'b0, stg_a[k][SEG-1:0]} + {1'b0, stg_b[k][SEG-1:0]}
                       + {{SEG{1'b0}}, stg_c[k]};
            nxt_s[k]   = (stg_s[k] >> SEG) | (WIDTH'(seg_sum[k][SEG-1:0]) << (WIDTH - SEG));
            nxt_a[k]   = stg_a[k] >> SEG;
            nxt_b[k]   = stg_b[k] >> SEG;
        end
    end

`ifdef RCA_PIPE_OVF_EN
    logic carry_into_msb;
    logic nxt_ovf;
    logic ovf_q;

    // Sum MSB = a ^ b ^ carry-in, so the carry into the MSB falls out of the sum bit.
    assign carry_into_msb = stg_a[NSEG-1][SEG-1] ^ stg_b[NSEG-1][SEG-1] ^ seg_sum[NSEG-1][SEG-1];
    assign nxt_ovf        = carry_into_msb ^ seg_sum[NSEG-1][SEG];
    assign ovf            = ovf_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (!stall && stg_v[NSEG-1]) begin
            ovf_q <= nxt_ovf;
        end
    end
`endif

    // Data only loads behind a valid token so the output holds across bubbles.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NSEG; k++) begin
                v_q[k] <= 1'b0;
                c_q[k] <= 1'b0;
                s_q[k] <= '0;
                a_q[k] <= '0;
                b_q[k] <= '0;
            end
        end else if (!stall) begin
            for (int k = 0; k < NSEG; k++) begin
                v_q[k] <= stg_v[k];
                if (stg_v[k]) begin
                    c_q[k] <= seg_sum[k][SEG];
                    s_q[k] <= nxt_s[k];
                    a_q[k] <= nxt_a[k];
                    b_q[k] <= nxt_b[k];
                end
            end
        end
    end

endmodule

// File: tb/tb_rca_pipe.sv
// Bench for rca_pipe (WIDTH=16, SEG=4): arithmetic model with a result queue, plus directed literal checks.
module tb_rca_pipe;

    localparam int WIDTH = 16;
    localparam int SEG   = 4;
    localparam int NSEG  = WIDTH / SEG;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] s;
    logic             cout;
`ifdef RCA_PIPE_OVF_EN
    logic             ovf;
`endif

    always #5 clk = ~clk;

    rca_pipe #(.WIDTH(WIDTH), .SEG(SEG)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .cout      (cout)
`ifdef RCA_PIPE_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    typedef struct {
        logic [WIDTH-1:0] s;
        logic             c;
        logic             v;
        int               cyc;
        int               stl;
    } exp_t;

    exp_t q[$];

    // Plain integer arithmetic; overflow from operand/result signs.
    function automatic exp_t model(input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb,
                                   input logic vc, input logic vs);
        exp_t             e;
        logic [WIDTH-1:0] be;
        logic [WIDTH:0]   r;
        be  = vs ? ~vb : vb;
        r   = {1'b0, va} + {1'b0, be} + (WIDTH+1)'(vs ? 1'b1 : vc);
        e.s = r[WIDTH-1:0];
        e.c = r[WIDTH];
        e.v = (va[WIDTH-1] == be[WIDTH-1]) && (r[WIDTH-1] != va[WIDTH-1]);
        e.cyc = 0;
        e.stl = 0;
        return e;
    endfunction

    int               cyc       = 0;
    int               stall_cnt = 0;
    int               consumed  = 0;
    bit               presented = 1'b0;
    logic [WIDTH-1:0] last_s    = '0;
    logic             last_c    = 1'b0;
    exp_t             acc_e;

    // Every stalled cycle delays everything in flight by exactly one cycle.
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            q.delete();
            presented = 1'b0;
            last_s    = '0;
            last_c    = 1'b0;
        end else begin
            chk("in_ready_rule", {31'b0, in_ready}, {31'b0, !(out_valid && !out_ready)});
            if (out_valid) begin
                if (q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL spurious_out actual=out_valid=1 s=%0h required=no result pending", s);
                end else begin
                    if (!presented) begin
                        chk("latency", cyc - q[0].cyc, NSEG + stall_cnt - q[0].stl);
                        presented = 1'b1;
                    end
                    chk("s", {16'b0, s}, {16'b0, q[0].s});
                    chk("cout", {31'b0, cout}, {31'b0, q[0].c});
`ifdef RCA_PIPE_OVF_EN
                    chk("ovf", {31'b0, ovf}, {31'b0, q[0].v});
`endif
                    if (out_ready) begin
                        void'(q.pop_front());
                        presented = 1'b0;
                        consumed++;
                    end
                end
                last_s = s;
                last_c = cout;
            end else begin
                chk("s_hold", {16'b0, s}, {16'b0, last_s});
                chk("cout_hold", {31'b0, cout}, {31'b0, last_c});
            end
            if (out_valid && !out_ready) stall_cnt++;
            if (in_valid && in_ready) begin
                acc_e     = model(a, b, cin, sub);
                acc_e.cyc = cyc;
                acc_e.stl = stall_cnt;
                q.push_back(acc_e);
            end
        end
    end

    task automatic send(input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb,
                        input logic vc, input logic vs);
        int n = 0;
        bit acc;
        a = va; b = vb; cin = vc; sub = vs; in_valid = 1'b1;
        do begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!acc && n < 100);
        if (!acc) begin
            checks++;
            failures++;
            $display("FAIL send_timeout actual=in_ready stuck low required=accept within 100 cycles");
        end
    endtask

    // Returns at the negedge where out_valid is seen; lat counts cycles since the accept edge.
    task automatic wait_out(output int lat);
        lat = 1;
        while (lat < 50) begin
            @(negedge clk);
            if (out_valid) break;
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic single(input string nm, input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb,
                          input logic vc, input logic vs, input logic [WIDTH-1:0] xs,
                          input logic xc, input logic xv);
        int lat;
        send(va, vb, vc, vs);
        in_valid = 1'b0;
        wait_out(lat);
        chk({nm, "_lat"}, lat, NSEG);
        chk({nm, "_s"}, {16'b0, s}, {16'b0, xs});
        chk({nm, "_cout"}, {31'b0, cout}, {31'b0, xc});
`ifdef RCA_PIPE_OVF_EN
        chk({nm, "_ovf"}, {31'b0, ovf}, {31'b0, xv});
`else
        if (xv === 1'bx) $display("note: bad overflow literal for %s", nm);
`endif
        @(posedge clk);
        #1;
    endtask

    logic [WIDTH-1:0] tab_a [8] = '{16'h0001, 16'h7FFF, 16'hFFFF, 16'h0F0F,
                                    16'hABCD, 16'h0000, 16'h1000, 16'h8000};
    logic [WIDTH-1:0] tab_b [8] = '{16'h0001, 16'h0001, 16'hFFFF, 16'hF0F0,
                                    16'h1234, 16'h0000, 16'h0FFF, 16'h8000};
    logic             tab_c [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    logic             tab_u [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

    initial begin
        int base;
        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_s", {16'b0, s}, 32'd0);
        chk("rst_cout", {31'b0, cout}, 32'd0);
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;

        single("add", 16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0);
        single("ripple", 16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
        single("sub_neg", 16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        single("sub_cin0", 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        single("sub_ovf", 16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1);

        // Back-to-back stream; per-item latency and ordering are checked by the compare process.
        base = consumed;
        for (int i = 0; i < 8; i++) send(tab_a[i], tab_b[i], tab_c[i], tab_u[i]);
        in_valid = 1'b0;
        repeat (NSEG + 3) @(posedge clk);
        #1;
        chk("stream_count", consumed - base, 8);

        // Backpressure mid-stream.
        base = consumed;
        fork
            begin
                for (int i = 1; i <= 10; i++) send(16'(i * 4099), 16'(i * 771), i[0], i[1]);
                in_valid = 1'b0;
            end
            begin
                repeat (5) @(posedge clk);
                #1;
                out_ready = 1'b0;
                @(negedge clk);
                chk("bp_out_valid", {31'b0, out_valid}, 32'd1);
                chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
                repeat (5) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        repeat (NSEG + 4) @(posedge clk);
        #1;
        chk("bp_count", consumed - base, 10);
        chk("bp_drained", q.size(), 0);

        // Reset with three results in flight.
        base = consumed;
        send(16'h0101, 16'h0202, 1'b0, 1'b0);
        send(16'h0303, 16'h0404, 1'b1, 1'b0);
        send(16'h0909, 16'h0505, 1'b0, 1'b1);
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("midrst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("midrst_s", {16'b0, s}, 32'd0);
        chk("midrst_cout", {31'b0, cout}, 32'd0);
        chk("midrst_in_ready", {31'b0, in_ready}, 32'd1);
`ifdef RCA_PIPE_OVF_EN
        chk("midrst_ovf", {31'b0, ovf}, 32'd0);
`endif
        repeat (NSEG + 4) @(posedge clk);
        #1;
        chk("midrst_none_emerge", consumed - base, 0);

        single("post_rst", 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog actual=still running required=finish before 200000");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

endmodule
